// File: rtl/cdf_div_unit_if.sv
// cdf_div_unit_if -- request/result bundle for the CDF equalisation divider.
//
// Signals:
//   enable      : stall control, low freezes the divider
//   start       : one-cycle request to latch operands and begin a job
//   cdfval      : CDF value of the current bin
//   cdf_min     : minimum non-zero CDF value
//   div_denom   : pixel count minus cdf_min
//   div_value   : equalised value (8 bits zero-extended to 32), registered
//   div_done    : sticky completion flag
//   div_by_zero : sticky flag, last job had div_denom = 0
//
// Modports: master drives the request side, slave is the divider.
interface cdf_div_unit_if;
    logic        enable;
    logic        start;
    logic [31:0] cdfval;
    logic [31:0] cdf_min;
    logic [31:0] div_denom;
    logic [31:0] div_value;
    logic        div_done;
    logic        div_by_zero;

    modport master (
        output enable, start, cdfval, cdf_min, div_denom,
        input  div_value, div_done, div_by_zero
    );

    modport slave (
        input  enable, start, cdfval, cdf_min, div_denom,
        output div_value, div_done, div_by_zero
    );
endinterface

// File: rtl/cdf_div_unit.sv
// cdf_div_unit -- histogram-equalisation divider.
//
// Computes div_value = min(255, floor(((cdfval - cdf_min) * 255) / div_denom))
// with a 40-bit restoring divider producing one quotient bit per enabled
// cycle. A job takes one PREP cycle plus 40 DIVIDE cycles; a zero
// denominator skips DIVIDE and reports 255 with div_by_zero set.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; clears all state
//   bus   : cdf_div_unit_if.slave (enable, start, operands, results)
//
// Build option:
//   CDF_DIV_ROUND_EN : when defined, adds div_denom/2 to a non-zero numerator
//                      so the result rounds to nearest (ties up). Latency is
//                      the same in both builds.
module cdf_div_unit (
    input  logic           clk,
    input  logic           reset,
    cdf_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state, state_next;

    logic [31:0] op_cdf, op_min, op_denom;
    logic [39:0] numer;     // shifted left each DIVIDE cycle, MSB feeds the remainder
    logic [39:0] rem;
    logic [39:0] quot;
    logic [5:0]  cnt;       // bit position being produced, 39 down to 0
    logic [7:0]  value_q;
    logic        done_q;
    logic        dbz_q;

    // ------------------------------------------------------------------
    // Numerator formation (used in PREP)
    // ------------------------------------------------------------------
    logic [31:0] diff;
    logic [39:0] numer_prep;

    always_comb begin
        diff       = op_cdf - op_min;
        numer_prep = '0;
        if (op_cdf >= op_min) begin
            // x*255 as x*256 - x; fits in 40 bits for any 32-bit x
            numer_prep = {diff, 8'd0} - {8'd0, diff};
        end
`ifdef CDF_DIV_ROUND_EN
        if (numer_prep != '0) begin
            numer_prep = numer_prep + {9'd0, op_denom[31:1]};
        end
`endif
    end

    // ------------------------------------------------------------------
    // One restoring-division step (used in DIVIDE)
    // ------------------------------------------------------------------
    logic [39:0] denom_ext;
    logic [39:0] rem_shift;
    logic        sub_ok;
    logic [39:0] rem_step;
    logic [39:0] quot_step;
    logic [7:0]  value_sat;

    always_comb begin
        denom_ext = {8'd0, op_denom};
        rem_shift = {rem[38:0], numer[39]};
        // rem stays below the 32-bit denominator, so rem[39] never sets in
        // practice; folding it in keeps the step correct regardless.
        sub_ok    = rem[39] | (rem_shift >= denom_ext);
        rem_step  = sub_ok ? (rem_shift - denom_ext) : rem_shift;
        quot_step = sub_ok ? (quot | (40'd1 << cnt)) : quot;
        value_sat = (quot_step[39:8] != '0) ? 8'hFF : quot_step[7:0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = PREP;
            PREP:    state_next = (op_denom == '0) ? DONE : DIVIDE;
            DIVIDE:  if (cnt == '0) state_next = DONE;
            DONE:    state_next = bus.start ? PREP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_cdf   <= '0;
            op_min   <= '0;
            op_denom <= '0;
            numer    <= '0;
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
            value_q  <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (bus.enable) begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_cdf   <= bus.cdfval;
                        op_min   <= bus.cdf_min;
                        op_denom <= bus.div_denom;
                        done_q   <= 1'b0;
                        dbz_q    <= 1'b0;
                    end
                end
                PREP: begin
                    numer <= numer_prep;
                    rem   <= '0;
                    quot  <= '0;
                    cnt   <= 6'd39;
                    if (op_denom == '0) begin
                        value_q <= 8'hFF;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b1;
                    end
                end
                DIVIDE: begin
                    numer <= numer << 1;
                    rem   <= rem_step;
                    quot  <= quot_step;
                    if (cnt == '0) begin
                        value_q <= value_sat;
                        done_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.div_value   = {24'd0, value_q};
    assign bus.div_done    = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_cdf_div_unit.sv
module tb_cdf_div_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef CDF_DIV_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    // 25500/1000 = 25.5 and 127500/1000 = 127.5 -> rounding bumps both
    localparam logic [31:0] EXP_25  = RND ? 32'd26  : 32'd25;
    localparam logic [31:0] EXP_127 = RND ? 32'd128 : 32'd127;

    cdf_div_unit_if bus();

    cdf_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Runs one job. Edge 1 is the edge that samples start. Optional events
    // (by edge number, 0 = none): a stall window, a second start with a
    // different cdfval, and a reset pulse. Returns the edge after which
    // div_done was seen (or the reset edge), -1 if the bound expired.
    task automatic run_job(input logic [31:0] c, input logic [31:0] m,
                           input logic [31:0] d, input int stall_at,
                           input int stall_len, input int restart_at,
                           input int reset_at, output int edges);
        edges = -1;
        @(negedge clk);
        bus.cdfval    = c;
        bus.cdf_min   = m;
        bus.div_denom = d;
        bus.enable    = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk);
        for (int n = 2; n <= 200; n++) begin
            @(negedge clk);
            bus.start  = (n == restart_at);
            if (n == restart_at) bus.cdfval = 32'd999;
            bus.enable = !(stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
            reset      = (n == reset_at);
            @(posedge clk);
            #1;
            if (n == reset_at || bus.div_done) begin
                edges = n;
                break;
            end
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.enable = 1'b1;
        reset      = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.div_value !== 32'd0) begin
            n_fail++; $display("FAIL reset_value got %0d want 0", bus.div_value);
        end
        n_tests++;
        if (bus.div_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done got %b want 0", bus.div_done);
        end
        n_tests++;
        if (bus.div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero);
        end
        n_tests++;
        if (dut.state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state got %0d want 0 (IDLE)", dut.state);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_scale;
        int e;
        run_job(32'd1000, 32'd0, 32'd1000, 0, 0, 0, 0, e);
        n_tests++;
        if (e !== 42) begin
            n_fail++; $display("FAIL full_latency got edge %0d want 42", e);
        end
        n_tests++;
        if (bus.div_value !== 32'd255) begin
            n_fail++; $display("FAIL full_value got %0d want 255", bus.div_value);
        end
        n_tests++;
        if (bus.div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL full_dbz got %b want 0", bus.div_by_zero);
        end
    endtask

    task automatic test_rounding;
        int e;
        run_job(32'd100, 32'd0, 32'd1000, 0, 0, 0, 0, e);
        n_tests++;
        if (e !== 42) begin
            n_fail++; $display("FAIL round_latency got edge %0d want 42", e);
        end
        n_tests++;
        if (bus.div_value !== EXP_25) begin
            n_fail++; $display("FAIL round_value got %0d want %0d", bus.div_value, EXP_25);
        end
    endtask

    task automatic test_saturate;
        int e;
        // 2000*255/1000 = 510 -> clamps to 255
        run_job(32'd2000, 32'd0, 32'd1000, 0, 0, 0, 0, e);
        n_tests++;
        if (bus.div_value !== 32'd255) begin
            n_fail++; $display("FAIL sat_value got %0d want 255", bus.div_value);
        end
        // 255/1000 = 0.255 -> 0 in both builds
        run_job(32'd1, 32'd0, 32'd1000, 0, 0, 0, 0, e);
        n_tests++;
        if (bus.div_value !== 32'd0) begin
            n_fail++; $display("FAIL small_value got %0d want 0", bus.div_value);
        end
    endtask

    task automatic test_div_by_zero;
        int e;
        bit seen;
        run_job(32'd7, 32'd0, 32'd0, 0, 0, 0, 0, e);
        n_tests++;
        if (e !== 2) begin
            n_fail++; $display("FAIL dbz_latency got edge %0d want 2", e);
        end
        n_tests++;
        if (bus.div_value !== 32'd255) begin
            n_fail++; $display("FAIL dbz_value got %0d want 255", bus.div_value);
        end
        n_tests++;
        if (bus.div_by_zero !== 1'b1 || bus.div_done !== 1'b1) begin
            n_fail++; $display("FAIL dbz_flags got dbz=%b done=%b want 1 1",
                               bus.div_by_zero, bus.div_done);
        end
        // next valid job: flags clear on the start edge, old value still held
        @(negedge clk);
        bus.cdfval = 32'd100; bus.cdf_min = 32'd0; bus.div_denom = 32'd1000;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.div_by_zero !== 1'b0 || bus.div_done !== 1'b0) begin
            n_fail++; $display("FAIL dbz_clear got dbz=%b done=%b want 0 0",
                               bus.div_by_zero, bus.div_done);
        end
        n_tests++;
        if (bus.div_value !== 32'd255) begin
            n_fail++; $display("FAIL value_hold got %0d want 255", bus.div_value);
        end
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.div_done) begin seen = 1'b1; break; end
        end
        n_tests++;
        if (!seen || bus.div_value !== EXP_25) begin
            n_fail++; $display("FAIL after_dbz done=%b value %0d want 1 %0d",
                               seen, bus.div_value, EXP_25);
        end
    endtask

    task automatic test_start_ignored;
        int e;
        run_job(32'd5, 32'd10, 32'd500, 0, 0, 20, 0, e);
        n_tests++;
        if (e !== 42) begin
            n_fail++; $display("FAIL restart_latency got edge %0d want 42", e);
        end
        n_tests++;
        if (bus.div_value !== 32'd0) begin
            n_fail++; $display("FAIL restart_value got %0d want 0", bus.div_value);
        end
    endtask

    task automatic test_stall;
        int e;
        run_job(32'd600, 32'd100, 32'd1000, 10, 3, 0, 0, e);
        n_tests++;
        if (e !== 45) begin
            n_fail++; $display("FAIL stall_latency got edge %0d want 45", e);
        end
        n_tests++;
        if (bus.div_value !== EXP_127) begin
            n_fail++; $display("FAIL stall_value got %0d want %0d", bus.div_value, EXP_127);
        end
    endtask

    task automatic test_reset_abort;
        int e;
        bit late_done;
        // DIVIDE cycle 10 is edge 12
        run_job(32'd600, 32'd100, 32'd1000, 0, 0, 0, 12, e);
        n_tests++;
        if (e !== 12 || bus.div_value !== 32'd0 || bus.div_done !== 1'b0 ||
            bus.div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs edge %0d value %0d done %b dbz %b want 12 0 0 0",
                               e, bus.div_value, bus.div_done, bus.div_by_zero);
        end
        n_tests++;
        if (dut.state !== 2'd0) begin
            n_fail++; $display("FAIL abort_state got %0d want 0 (IDLE)", dut.state);
        end
        late_done = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (bus.div_done || bus.div_value != 32'd0) late_done = 1'b1;
        end
        n_tests++;
        if (late_done !== 1'b0) begin
            n_fail++; $display("FAIL abort_quiet got activity=%b want 0", late_done);
        end
    endtask

    initial begin
        bus.enable    = 1'b1;
        bus.start     = 1'b0;
        bus.cdfval    = '0;
        bus.cdf_min   = '0;
        bus.div_denom = '0;
        test_reset();
        test_full_scale();
        test_rounding();
        test_saturate();
        test_div_by_zero();
        test_start_ignored();
        test_stall();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
